// File: rtl/prefetch_buffer.sv
// Prefetch buffer: dedups prefetch addresses, issues them in order over a single-outstanding
// memory request channel, and serves demand lookups. Optional macro: PFB_DEMAND_CANCEL_EN.
module prefetch_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 16,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pf_v,
    input  logic [AW-1:0] pf_addr,
    output logic          pf_drop,
    output logic          mem_req_v,
    output logic [AW-1:0] mem_req_addr,
    input  logic          mem_req_ready,
    input  logic          mem_resp_v,
    input  logic [DW-1:0] mem_resp_data,
    input  logic          demand_v,
    input  logic [AW-1:0] demand_addr,
    output logic          demand_hit,
    output logic [DW-1:0] demand_data
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    typedef enum logic [1:0] {
        ST_INVALID,
        ST_PENDING,
        ST_INFLIGHT,
        ST_READY
    } ent_state_e;

    ent_state_e    state_q [DEPTH];
    ent_state_e    state_d [DEPTH];
    logic [AW-1:0] addr_q  [DEPTH];
    logic [AW-1:0] addr_d  [DEPTH];
    logic [DW-1:0] data_q  [DEPTH];
    logic [DW-1:0] data_d  [DEPTH];

    // Issue queue: entry indices of PENDING entries in allocation order, head at slot 0.
    logic [IW-1:0] q_idx_q [DEPTH];
    logic [IW-1:0] q_idx_d [DEPTH];
    logic [CW-1:0] q_cnt_q, q_cnt_d;
    logic [CW-1:0] q_wr;

    logic          outstanding_q, outstanding_d;
    logic          mem_req_v_q, mem_req_v_d;
    logic [AW-1:0] mem_req_addr_q, mem_req_addr_d;
    logic [IW-1:0] req_idx_q, req_idx_d;
    logic          pf_drop_q, pf_drop_d;
    logic          demand_hit_q, demand_hit_d;
    logic [DW-1:0] demand_data_q, demand_data_d;

    logic [DEPTH-1:0] pf_match, free_vec, hit_vec, cancel_vec, rm_vec;
    logic [IW-1:0]    alloc_idx;
    logic             alloc, hs, resp_fire, head_cancel;

    assign hs        = mem_req_v_q && mem_req_ready;
    assign resp_fire = mem_resp_v && outstanding_q;

    // Decisions below look only at pre-edge state, so a slot freed this cycle stays unusable.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch can be inferred.
        pf_match   = '0;
        free_vec   = '0;
        hit_vec    = '0;
        cancel_vec = '0;
        alloc_idx  = '0;
        for (int e = 0; e < DEPTH; e++) begin
            pf_match[e] = (state_q[e] != ST_INVALID) && (addr_q[e] == pf_addr);
            free_vec[e] = (state_q[e] == ST_INVALID);
            hit_vec[e]  = demand_v && (state_q[e] == ST_READY) && (addr_q[e] == demand_addr);
`ifdef PFB_DEMAND_CANCEL_EN
            // A handshake in the same cycle wins: the entry goes INFLIGHT and is kept.
            cancel_vec[e] = demand_v && (state_q[e] == ST_PENDING) && (addr_q[e] == demand_addr)
                            && !(hs && (IW'(e) == req_idx_q));
`endif
        end
        for (int e = DEPTH - 1; e >= 0; e--) begin
            if (free_vec[e]) begin
                alloc_idx = IW'(e);
            end
        end
        alloc  = pf_v && !(|pf_match) && (|free_vec);
        rm_vec = cancel_vec;
        if (hs) begin
            rm_vec[req_idx_q] = 1'b1;
        end
        head_cancel = (q_cnt_q != '0) && cancel_vec[q_idx_q[0]];
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        for (int e = 0; e < DEPTH; e++) begin
            if (hit_vec[e] || cancel_vec[e]) begin
                state_d[e] = ST_INVALID;
            end
            if (hs && (IW'(e) == req_idx_q)) begin
                state_d[e] = ST_INFLIGHT;
            end
            if (resp_fire && (state_q[e] == ST_INFLIGHT)) begin
                state_d[e] = ST_READY;
                data_d[e]  = mem_resp_data;
            end
            if (alloc && (IW'(e) == alloc_idx)) begin
                state_d[e] = ST_PENDING;
                addr_d[e]  = pf_addr;
            end
        end
    end

    // Compact the queue around removed entries, then append the new allocation.
    always_comb begin
        q_idx_d = q_idx_q;
        q_wr    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < q_cnt_q) && !rm_vec[q_idx_q[i]]) begin
                q_idx_d[q_wr[IW-1:0]] = q_idx_q[i];
                q_wr                  = q_wr + CW'(1);
            end
        end
        if (alloc) begin
            q_idx_d[q_wr[IW-1:0]] = alloc_idx;
            q_wr                  = q_wr + CW'(1);
        end
        q_cnt_d = q_wr;
    end

    always_comb begin
        outstanding_d  = outstanding_q;
        mem_req_v_d    = mem_req_v_q;
        mem_req_addr_d = mem_req_addr_q;
        req_idx_d      = req_idx_q;
        if (resp_fire) begin
            outstanding_d = 1'b0;
        end
        if (hs) begin
            outstanding_d = 1'b1;
            mem_req_v_d   = 1'b0;
        end else if (mem_req_v_q) begin
            if (cancel_vec[req_idx_q]) begin
                mem_req_v_d = 1'b0;
            end
        end else if (!outstanding_q && (q_cnt_q != '0) && !head_cancel) begin
            mem_req_v_d    = 1'b1;
            req_idx_d      = q_idx_q[0];
            mem_req_addr_d = addr_q[q_idx_q[0]];
        end
    end

    always_comb begin
        pf_drop_d     = pf_v && !alloc;
        demand_hit_d  = |hit_vec;
        demand_data_d = '0;
        for (int e = 0; e < DEPTH; e++) begin
            if (hit_vec[e]) begin
                demand_data_d = demand_data_d | data_q[e];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int e = 0; e < DEPTH; e++) begin
                state_q[e] <= ST_INVALID;
                q_idx_q[e] <= '0;
            end
            q_cnt_q        <= '0;
            outstanding_q  <= 1'b0;
            mem_req_v_q    <= 1'b0;
            mem_req_addr_q <= '0;
            req_idx_q      <= '0;
            pf_drop_q      <= 1'b0;
            demand_hit_q   <= 1'b0;
            demand_data_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop updating from pre-edge values.
            state_q        <= state_d;
            q_idx_q        <= q_idx_d;
            q_cnt_q        <= q_cnt_d;
            outstanding_q  <= outstanding_d;
            mem_req_v_q    <= mem_req_v_d;
            mem_req_addr_q <= mem_req_addr_d;
            req_idx_q      <= req_idx_d;
            pf_drop_q      <= pf_drop_d;
            demand_hit_q   <= demand_hit_d;
            demand_data_q  <= demand_data_d;
        end
    end

    // NOTE: address/data storage is not reset; entry state gates every read of it.
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
    end

    assign pf_drop      = pf_drop_q;
    assign mem_req_v    = mem_req_v_q;
    assign mem_req_addr = mem_req_addr_q;
    assign demand_hit   = demand_hit_q;
    assign demand_data  = demand_data_q;

endmodule

// File: tb/tb_prefetch_buffer.sv
// Self-checking bench for prefetch_buffer: directed scenarios plus random traffic,
// all checked against a queue/set-based reference model.
module tb_prefetch_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 16;
    localparam int DW    = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          pf_v;
    logic [AW-1:0] pf_addr;
    logic          pf_drop;
    logic          mem_req_v;
    logic [AW-1:0] mem_req_addr;
    logic          mem_req_ready;
    logic          mem_resp_v;
    logic [DW-1:0] mem_resp_data;
    logic          demand_v;
    logic [AW-1:0] demand_addr;
    logic          demand_hit;
    logic [DW-1:0] demand_data;

    always #5 clk = ~clk;

    prefetch_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .pf_v         (pf_v),
        .pf_addr      (pf_addr),
        .pf_drop      (pf_drop),
        .mem_req_v    (mem_req_v),
        .mem_req_addr (mem_req_addr),
        .mem_req_ready(mem_req_ready),
        .mem_resp_v   (mem_resp_v),
        .mem_resp_data(mem_resp_data),
        .demand_v     (demand_v),
        .demand_addr  (demand_addr),
        .demand_hit   (demand_hit),
        .demand_data  (demand_data)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: pending addresses in allocation order, one in-flight address,
    // and a map of ready address -> data.
    logic [AW-1:0] m_pend[$];
    bit            m_out;
    logic [AW-1:0] m_out_addr;
    logic [DW-1:0] m_ready[logic [AW-1:0]];
    logic          e_drop, e_req_v, e_hit;
    logic [AW-1:0] e_req_addr;
    logic [DW-1:0] e_data;
    logic [AW-1:0] issued[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    function automatic bit in_pend(input logic [AW-1:0] a);
        foreach (m_pend[i]) if (m_pend[i] == a) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_pend.delete();
        m_ready.delete();
        m_out      = 1'b0;
        m_out_addr = '0;
        e_drop     = 1'b0;
        e_req_v    = 1'b0;
        e_req_addr = '0;
        e_hit      = 1'b0;
        e_data     = '0;
    endtask

    task automatic model_step();
        bit            hs, resp, hit, dup, full, cancel, head_cancel, old_req_v, old_out, pend_ne;
        int            live;
        logic [AW-1:0] head;
        if (rst) begin
            model_reset();
            return;
        end
        live      = m_pend.size() + (m_out ? 1 : 0) + m_ready.num();
        old_req_v = e_req_v;
        old_out   = m_out;
        pend_ne   = (m_pend.size() != 0);
        head      = pend_ne ? m_pend[0] : '0;
        hs        = e_req_v && mem_req_ready;
        resp      = mem_resp_v && m_out;
        hit       = demand_v && m_ready.exists(demand_addr);
        dup       = pf_v && (in_pend(pf_addr) || (m_out && m_out_addr == pf_addr) || m_ready.exists(pf_addr));
        full      = (live >= DEPTH);
        cancel    = 1'b0;
`ifdef PFB_DEMAND_CANCEL_EN
        cancel = demand_v && !hit && in_pend(demand_addr) && !(hs && demand_addr == e_req_addr);
`endif
        head_cancel = cancel && pend_ne && (demand_addr == head);

        e_drop = pf_v && (dup || full);
        e_hit  = hit;
        e_data = hit ? m_ready[demand_addr] : '0;
        if (hit) m_ready.delete(demand_addr);
        if (resp) begin
            m_ready[m_out_addr] = mem_resp_data;
            m_out = 1'b0;
        end
        if (hs) begin
            m_out_addr = m_pend.pop_front();
            m_out      = 1'b1;
        end
        if (cancel) begin
            foreach (m_pend[i]) begin
                if (m_pend[i] == demand_addr) begin
                    m_pend.delete(i);
                    break;
                end
            end
        end
        if (pf_v && !dup && !full) m_pend.push_back(pf_addr);

        if (hs) begin
            e_req_v = 1'b0;
        end else if (old_req_v) begin
            if (head_cancel) e_req_v = 1'b0;
        end else if (!old_out && pend_ne && !head_cancel) begin
            e_req_v    = 1'b1;
            e_req_addr = head;
        end
    endtask

    task automatic set_in(input logic pv, input logic [AW-1:0] pa, input logic rdy,
                          input logic rv, input logic [DW-1:0] rd,
                          input logic dv, input logic [AW-1:0] da);
        pf_v          = pv;
        pf_addr       = pa;
        mem_req_ready = rdy;
        mem_resp_v    = rv;
        mem_resp_data = rd;
        demand_v      = dv;
        demand_addr   = da;
    endtask

    // One clock: inputs already driven; model advances, DUT sampled 1 time unit after the edge.
    task automatic cyc();
        if (mem_req_v && mem_req_ready && !rst) issued.push_back(mem_req_addr);
        model_step();
        @(posedge clk);
        #1;
        check("pf_drop", 32'(pf_drop), 32'(e_drop));
        check("mem_req_v", 32'(mem_req_v), 32'(e_req_v));
        check("mem_req_addr", 32'(mem_req_addr), 32'(e_req_addr));
        check("demand_hit", 32'(demand_hit), 32'(e_hit));
        check("demand_data", 32'(demand_data), 32'(e_data));
    endtask

    // Behave as memory: always ready, answer the outstanding request the cycle after it is taken.
    task automatic mem_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            set_in(1'b0, '0, 1'b1, m_out, DW'($urandom), 1'b0, '0);
            cyc();
        end
    endtask

    task automatic do_reset();
        set_in(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, '0);
        rst = 1'b1;
        #1;
        check("rst_req_v_async", 32'(mem_req_v), 32'd0);
        check("rst_drop", 32'(pf_drop), 32'd0);
        check("rst_hit", 32'(demand_hit), 32'd0);
        model_reset();
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        set_in(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, '0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_pf_drop", 32'(pf_drop), 32'd0);
        check("reset_req_v", 32'(mem_req_v), 32'd0);
        check("reset_req_addr", 32'(mem_req_addr), 32'd0);
        check("reset_hit", 32'(demand_hit), 32'd0);
        check("reset_data", 32'(demand_data), 32'd0);
        rst = 1'b0;

        // Basic fetch, hit, then the consumed entry misses.
        set_in(1'b1, 16'h0040, 1'b1, 1'b0, '0, 1'b0, '0); cyc();
        set_in(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, '0);       cyc();
        check("t1_req_v", 32'(mem_req_v), 32'd1);
        check("t1_req_addr", 32'(mem_req_addr), 32'h0040);
        cyc();
        check("t1_req_v_after_hs", 32'(mem_req_v), 32'd0);
        set_in(1'b0, '0, 1'b1, 1'b1, 16'hBEEF, 1'b0, '0); cyc();
        set_in(1'b0, '0, 1'b1, 1'b0, '0, 1'b1, 16'h0040); cyc();
        check("t1_hit", 32'(demand_hit), 32'd1);
        check("t1_data", 32'(demand_data), 32'hBEEF);
        cyc();
        check("t1_second_hit", 32'(demand_hit), 32'd0);
        check("t1_second_data", 32'(demand_data), 32'd0);

        // Duplicate prefetch on consecutive cycles.
        issued.delete();
        set_in(1'b1, 16'h0010, 1'b1, 1'b0, '0, 1'b0, '0); cyc();
        check("t2_first_drop", 32'(pf_drop), 32'd0);
        cyc();
        check("t2_dup_drop", 32'(pf_drop), 32'd1);
        mem_cycles(8);
        check("t2_issue_cnt", 32'(issued.size()), 32'd1);
        if (issued.size() >= 1) check("t2_issue_addr", 32'(issued[0]), 32'h0010);
        set_in(1'b0, '0, 1'b1, 1'b0, '0, 1'b1, 16'h0010); cyc();
        check("t2_hit", 32'(demand_hit), 32'd1);

        // Fill the buffer with ready low; the fifth prefetch is dropped, then ordered issue.
        issued.delete();
        for (int k = 1; k <= 5; k++) begin
            set_in(1'b1, AW'(k), 1'b0, 1'b0, '0, 1'b0, '0);
            cyc();
        end
        check("t3_full_drop", 32'(pf_drop), 32'd1);
        mem_cycles(16);
        check("t3_issue_cnt", 32'(issued.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
            if (k < issued.size()) check("t3_issue_order", 32'(issued[k]), 32'(k + 1));
        end
        for (int k = 1; k <= 4; k++) begin
            set_in(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, AW'(k));
            cyc();
            check("t3_drain_hit", 32'(demand_hit), 32'd1);
        end

        // Request held without ready, then reset mid-hold and a late response.
        set_in(1'b1, 16'h0020, 1'b0, 1'b0, '0, 1'b0, '0); cyc();
        set_in(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, '0);       cyc();
        for (int k = 0; k < 5; k++) begin
            cyc();
            check("t4_hold_v", 32'(mem_req_v), 32'd1);
            check("t4_hold_addr", 32'(mem_req_addr), 32'h0020);
        end
        do_reset();
        set_in(1'b0, '0, 1'b0, 1'b1, 16'hDEAD, 1'b0, '0); cyc();
        set_in(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 16'h0020); cyc();
        check("t4_miss_hit", 32'(demand_hit), 32'd0);
        check("t4_miss_data", 32'(demand_data), 32'd0);

        // Response and demand for the same in-flight entry in one cycle.
        set_in(1'b1, 16'h0030, 1'b1, 1'b0, '0, 1'b0, '0); cyc();
        set_in(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, '0);       cyc();
        cyc();
        set_in(1'b0, '0, 1'b1, 1'b1, 16'h1234, 1'b1, 16'h0030); cyc();
        check("t5_same_cycle_hit", 32'(demand_hit), 32'd0);
        set_in(1'b0, '0, 1'b1, 1'b0, '0, 1'b1, 16'h0030); cyc();
        check("t5_next_hit", 32'(demand_hit), 32'd1);
        check("t5_next_data", 32'(demand_data), 32'h1234);

        // Demand miss on a pending entry.
        issued.delete();
        set_in(1'b1, 16'h0050, 1'b0, 1'b0, '0, 1'b0, '0); cyc();
        set_in(1'b1, 16'h0060, 1'b0, 1'b0, '0, 1'b0, '0); cyc();
        set_in(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 16'h0060); cyc();
        check("t6_pending_miss", 32'(demand_hit), 32'd0);
        mem_cycles(12);
        if (issued.size() >= 1) check("t6_first_issue", 32'(issued[0]), 32'h0050);
`ifdef PFB_DEMAND_CANCEL_EN
        check("t6_issue_cnt", 32'(issued.size()), 32'd1);
`else
        check("t6_issue_cnt", 32'(issued.size()), 32'd2);
        if (issued.size() >= 2) check("t6_second_issue", 32'(issued[1]), 32'h0060);
        set_in(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 16'h0060); cyc();
`endif
        set_in(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 16'h0050); cyc();
        check("t6_drain_hit", 32'(demand_hit), 32'd1);

        // Random traffic over a small address pool to provoke duplicates, fills and collisions.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                set_in($urandom_range(0, 1) == 1, AW'(16'h0100 + $urandom_range(0, 7)),
                       $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0, DW'($urandom),
                       $urandom_range(0, 1) == 1, AW'(16'h0100 + $urandom_range(0, 7)));
                cyc();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
